rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 18 +
 rtl/rf_wb_arbiter_wb_fifo.sv | 76 +++++++
 rtl/rf_wb_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths and write-entry record for the writeback arbiter
package rf_wb_arbiter_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    // Register $0 never counts as a dependency.
    function automatic logic addr_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// rtl/rf_wb_arbiter_wb_fifo.sv - MDU result queue with per-entry invalidation by address
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          inval_en,
    input  logic [AW-1:0] inval_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output wb_entry_t     head,
    output logic          empty,
    output logic          full,
    output logic          src_hit
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Invalidation only touches entries already stored; a same-cycle push is newer.
            for (int i = 0; i < DEPTH; i++) begin
                if (inval_en && mem[i].valid && (mem[i].addr == inval_addr)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr].valid <= 1'b1;
                mem[wr_ptr].addr  <= push_addr;
                mem[wr_ptr].data  <= push_data;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid && (addr_hit(rs_addr, mem[i].addr) || addr_hit(rt_addr, mem[i].addr))) begin
                src_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter between pipeline writeback and MDU results
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic [AW-1:0] mdu_waddr,
    input  logic [DW-1:0] mdu_wdata,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic          src_pending,
    output logic          stall_req,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          skid_valid;
    logic [AW-1:0] skid_addr;
    logic [DW-1:0] skid_data;
    logic [SW-1:0] starve;
    logic          ready_q;

    wb_entry_t     head;
    logic          q_empty;
    logic          q_full;
    logic          q_hit;

    logic          pipe_acc;
    logic          mdu_push;
    logic          head_live;
    logic          forced;
    logic          fifo_pop;
    logic          head_pop;
    logic          skid_load;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    assign pipe_acc  = pipe_we && (pipe_waddr != '0);
    assign mdu_push  = mdu_valid && mdu_ready && (mdu_waddr != '0);
    assign head_live = !q_empty && head.valid;
    assign forced    = head_live && (starve == SW'(STARVE_LIMIT)) && !skid_valid;
    // Superseded heads drain without consuming the write port.
    assign fifo_pop  = head_pop || (!q_empty && !head.valid);

    assign mdu_ready   = ready_q && !q_full;
    assign stall_req   = skid_valid || forced;
    assign src_pending = q_hit ||
                         (skid_valid && (addr_hit(rs_addr, skid_addr) || addr_hit(rt_addr, skid_addr)));

    always_comb begin
        g_we      = 1'b0;
        g_addr    = '0;
        g_data    = '0;
        head_pop  = 1'b0;
        skid_load = 1'b0;
        if (skid_valid) begin
            g_we      = 1'b1;
            g_addr    = skid_addr;
            g_data    = skid_data;
            skid_load = pipe_acc;
        end else if (forced) begin
            g_we      = 1'b1;
            g_addr    = head.addr;
            g_data    = head.data;
            head_pop  = 1'b1;
            skid_load = pipe_acc;
        end else if (pipe_acc) begin
            g_we   = 1'b1;
            g_addr = pipe_waddr;
            g_data = pipe_wdata;
        end else if (head_live) begin
            g_we     = 1'b1;
            g_addr   = head.addr;
            g_data   = head.data;
            head_pop = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
            starve     <= '0;
            ready_q    <= 1'b0;
        end else begin
            rf_we    <= g_we;
            rf_waddr <= g_addr;
            rf_wdata <= g_data;
            ready_q  <= 1'b1;
            if (skid_load) begin
                skid_valid <= 1'b1;
                skid_addr  <= pipe_waddr;
                skid_data  <= pipe_wdata;
            end else begin
                skid_valid <= 1'b0;
            end
            if (q_empty || fifo_pop) begin
                starve <= '0;
            end else if (starve != SW'(STARVE_LIMIT)) begin
                starve <= starve + SW'(1);
            end
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mdu_push),
        .push_addr (mdu_waddr),
        .push_data (mdu_wdata),
        .pop       (fifo_pop),
        .inval_en  (pipe_acc),
        .inval_addr(pipe_waddr),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .head      (head),
        .empty     (q_empty),
        .full      (q_full),
        .src_hit   (q_hit)
    );

endmodule
